hsc_ddr2_local_model: RTL and testbench

Synthesizable responder for the DDR2 controller's local (user-side) interface. It answers `local_write_req` / `local_read_req` bursts from the FIFO controller exactly as the DDR2 controller does, using on-chip block RAM instead of external memory. It lets the FIFO controller and user ports be exercised in simulation and on boards without DDR2 hardware. It sits in place of the DDR2 controller, clocked by the same operate clock.

---
 rtl/hsc_ddr2_local_if.sv | 33 +++
 rtl/hsc_ddr2_local_model.sv | 188 ++++++++++++++++++
 tb/tb_hsc_ddr2_local_model.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hsc_ddr2_local_if.sv
// Local (user-side) DDR2 controller bus between the FIFO controller and the
// memory responder.
interface hsc_ddr2_local_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   local_address;
    logic                local_write_req;
    logic                local_read_req;
    logic                local_burstbegin;
    logic [DATA_W-1:0]   local_wdata;
    logic [DATA_W/8-1:0] local_be;
    logic [6:0]          local_size;
    logic                local_ready;
    logic [DATA_W-1:0]   local_rdata;
    logic                local_rdata_valid;
    logic                local_init_done;
    logic                local_refresh_ack;

    modport master (
        output local_address, local_write_req, local_read_req, local_burstbegin,
               local_wdata, local_be, local_size,
        input  local_ready, local_rdata, local_rdata_valid, local_init_done,
               local_refresh_ack
    );

    modport slave (
        input  local_address, local_write_req, local_read_req, local_burstbegin,
               local_wdata, local_be, local_size,
        output local_ready, local_rdata, local_rdata_valid, local_init_done,
               local_refresh_ack
    );
endinterface

// File: rtl/hsc_ddr2_local_model.sv
// Block-RAM stand-in for the DDR2 controller local interface: init delay,
// byte-enabled write bursts, fixed-latency read bursts and periodic refresh.
module hsc_ddr2_local_model #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 32,
    parameter int MEM_AW         = 10,
    parameter int INIT_CYCLES    = 64,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_PERIOD = 512,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    hsc_ddr2_local_if.slave  lif
);
    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_IDLE    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_READ    = 3'd3;
    localparam logic [2:0] ST_REFRESH = 3'd4;

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int REF_W  = $clog2(REFRESH_PERIOD + 1);
    localparam int HOLD_W = $clog2(REFRESH_CYCLES + 1);

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic [6:0]        left;
    } burst_t;

    logic [2:0]        state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    logic [REF_W-1:0]  ref_cnt_q, ref_cnt_d;
    logic              ref_pending_q, ref_pending_d;
    logic [HOLD_W-1:0] ref_hold_q, ref_hold_d;
    logic              ref_ack_q, ref_ack_d;
    burst_t            burst_q, burst_d;
    logic [6:0]        beats_q, beats_d;
    logic [RD_LATENCY-1:0]              vld_pipe_q, vld_pipe_d;
    logic [RD_LATENCY-1:1][DATA_W-1:0]  dat_pipe_q, dat_pipe_d;

    logic [DATA_W-1:0] mem [2**MEM_AW];
    logic [DATA_W-1:0] ram_q;
    logic              ram_we;
    logic [MEM_AW-1:0] ram_waddr;
    logic [MEM_AW-1:0] ram_raddr;
    logic              rd_issue;
    logic [6:0]        eff_size;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^lif.local_address[ADDR_W-1:MEM_AW];

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        init_done_d   = init_done_q;
        ref_cnt_d     = ref_cnt_q;
        ref_pending_d = ref_pending_q;
        ref_hold_d    = ref_hold_q;
        ref_ack_d     = 1'b0;
        burst_d       = burst_q;
        beats_d       = beats_q;
        ram_we        = 1'b0;
        ram_waddr     = burst_q.addr;
        ram_raddr     = burst_q.addr;
        rd_issue      = 1'b0;
        eff_size      = (lif.local_size == 7'd0) ? 7'd1 : lif.local_size;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // Refresh outranks new work; local_ready is already low here.
                if (ref_pending_q) begin
                    state_d    = ST_REFRESH;
                    ref_ack_d  = 1'b1;
                    ref_hold_d = '0;
                end else if (lif.local_burstbegin && lif.local_write_req) begin
                    ram_we       = 1'b1;
                    ram_waddr    = lif.local_address[MEM_AW-1:0];
                    burst_d.addr = lif.local_address[MEM_AW-1:0] + 1'b1;
                    burst_d.left = eff_size - 7'd1;
                    if (eff_size != 7'd1) state_d = ST_WRITE;
                end else if (lif.local_burstbegin && lif.local_read_req) begin
                    rd_issue     = 1'b1;
                    ram_raddr    = lif.local_address[MEM_AW-1:0];
                    burst_d.addr = lif.local_address[MEM_AW-1:0] + 1'b1;
                    burst_d.left = eff_size - 7'd1;
                    beats_d      = eff_size - 7'd1;
                    state_d      = ST_READ;
                end
            end
            ST_WRITE: begin
                if (lif.local_write_req) begin
                    ram_we       = 1'b1;
                    burst_d.addr = burst_q.addr + 1'b1;
                    burst_d.left = burst_q.left - 7'd1;
                    if (burst_q.left == 7'd1) state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (burst_q.left != 7'd0) begin
                    rd_issue     = 1'b1;
                    burst_d.addr = burst_q.addr + 1'b1;
                    burst_d.left = burst_q.left - 7'd1;
                end
                // Issue finishes well before the last beat emerges, so exit on output count.
                if (vld_pipe_q[RD_LATENCY-1]) begin
                    if (beats_q == 7'd0) state_d = ST_IDLE;
                    else                 beats_d = beats_q - 7'd1;
                end
            end
            ST_REFRESH: begin
                if (ref_hold_q == HOLD_W'(REFRESH_CYCLES - 1)) begin
                    state_d       = ST_IDLE;
                    ref_pending_d = 1'b0;
                end else begin
                    ref_hold_d = ref_hold_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Period counter free-runs after init so bursts never delay the schedule.
        if (state_q != ST_INIT) begin
            if (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1)) begin
                ref_cnt_d     = '0;
                ref_pending_d = 1'b1;
            end else begin
                ref_cnt_d = ref_cnt_q + 1'b1;
            end
        end

        vld_pipe_d    = {vld_pipe_q[RD_LATENCY-2:0], rd_issue};
        dat_pipe_d    = dat_pipe_q;
        dat_pipe_d[1] = ram_q;
        for (int i = 2; i < RD_LATENCY; i++) dat_pipe_d[i] = dat_pipe_q[i-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            init_done_q   <= 1'b0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            ref_hold_q    <= '0;
            ref_ack_q     <= 1'b0;
            burst_q       <= '0;
            beats_q       <= '0;
            vld_pipe_q    <= '0;
            dat_pipe_q    <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            init_done_q   <= init_done_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            ref_hold_q    <= ref_hold_d;
            ref_ack_q     <= ref_ack_d;
            burst_q       <= burst_d;
            beats_q       <= beats_d;
            vld_pipe_q    <= vld_pipe_d;
            dat_pipe_q    <= dat_pipe_d;
        end
    end

    // Plain BRAM: no reset, so contents survive rst_n.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W/8; b++) begin
            if (ram_we && lif.local_be[b]) mem[ram_waddr][8*b +: 8] <= lif.local_wdata[8*b +: 8];
        end
        ram_q <= mem[ram_raddr];
    end

    assign lif.local_ready       = ((state_q == ST_IDLE) && !ref_pending_q) || (state_q == ST_WRITE);
    assign lif.local_rdata       = dat_pipe_q[RD_LATENCY-1];
    assign lif.local_rdata_valid = vld_pipe_q[RD_LATENCY-1];
    assign lif.local_init_done   = init_done_q;
    assign lif.local_refresh_ack = ref_ack_q;
endmodule

// File: tb/tb_hsc_ddr2_local_model.sv
// Scoreboard bench for hsc_ddr2_local_model; refresh period shortened to 32
// so refresh interacts with ordinary traffic.
module tb_hsc_ddr2_local_model;
    localparam int RD_LAT   = 4;
    localparam int INIT_CYC = 64;
    localparam int REF_PER  = 32;
    localparam int REF_CYC  = 8;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sbq[$];
    logic [31:0] mdl [1024];
    logic [31:0] wd  [8];
    logic [3:0]  wbe [8];

    hsc_ddr2_local_if #(.ADDR_W(24), .DATA_W(32)) ifc ();

    hsc_ddr2_local_model #(
        .ADDR_W(24), .DATA_W(32), .MEM_AW(10), .INIT_CYCLES(INIT_CYC),
        .RD_LATENCY(RD_LAT), .REFRESH_PERIOD(REF_PER), .REFRESH_CYCLES(REF_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .lif   (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void mwrite(input logic [9:0] idx, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic idle_inputs();
        ifc.local_address    = '0;
        ifc.local_write_req  = 1'b0;
        ifc.local_read_req   = 1'b0;
        ifc.local_burstbegin = 1'b0;
        ifc.local_wdata      = '0;
        ifc.local_be         = '0;
        ifc.local_size       = '0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (ifc.local_rdata_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL rdata_unexpected: valid at cycle %0d data %h, none expected", cyc, ifc.local_rdata);
                end else begin
                    e = sbq.pop_front();
                    if (ifc.local_rdata !== e.d || cyc != e.due) begin
                        errors++;
                        $display("FAIL rdata_beat: got %h at cycle %0d, expected %h at cycle %0d",
                                 ifc.local_rdata, cyc, e.d, e.due);
                    end
                end
            end
        end
    endtask

    // Expects to start just after a rising edge; returns just after one.
    task automatic wr_burst(input logic [23:0] a, input logic [6:0] sz, input int gap_at, input int gap_len);
        int n;
        bit ok;
        n = (sz == 7'd0) ? 1 : int'(sz);
        ifc.local_address    = a;
        ifc.local_size       = sz;
        ifc.local_burstbegin = 1'b1;
        ifc.local_write_req  = 1'b1;
        ifc.local_wdata      = wd[0];
        ifc.local_be         = wbe[0];
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ifc.local_ready) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wr_accept: ready=0 for 300 cycles, required 1"); end
        mwrite(a[9:0], wd[0], wbe[0]);
        for (int k = 1; k < n; k++) begin
            @(posedge clk); #1;
            if (k == gap_at) begin
                // Stray read/burstbegin during the gap must be ignored mid-write.
                ifc.local_write_req  = 1'b0;
                ifc.local_read_req   = 1'b1;
                ifc.local_burstbegin = 1'b1;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    checks++;
                    if (ifc.local_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL wr_gap_ready: got %b, required 1", ifc.local_ready);
                    end
                    @(posedge clk); #1;
                end
                ifc.local_read_req = 1'b0;
            end
            ifc.local_burstbegin = 1'b0;
            ifc.local_write_req  = 1'b1;
            ifc.local_wdata      = wd[k];
            ifc.local_be         = wbe[k];
            @(negedge clk);
            checks++;
            if (ifc.local_ready !== 1'b1) begin
                errors++;
                $display("FAIL wr_beat_ready: beat %0d got %b, required 1", k, ifc.local_ready);
            end
            mwrite(a[9:0] + 10'(k), wd[k], wbe[k]);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Returns in cycle t0+1, just after the edge.
    task automatic rd_burst(input logic [23:0] a, input logic [6:0] sz, output int t0);
        int n;
        exp_t e;
        n = (sz == 7'd0) ? 1 : int'(sz);
        ifc.local_address    = a;
        ifc.local_size       = sz;
        ifc.local_burstbegin = 1'b1;
        ifc.local_read_req   = 1'b1;
        t0 = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ifc.local_ready) begin t0 = cyc; break; end
        end
        checks++;
        if (t0 < 0) begin
            errors++;
            $display("FAIL rd_accept: ready=0 for 300 cycles, required 1");
        end else begin
            for (int k = 0; k < n; k++) begin
                e.d   = mdl[a[9:0] + 10'(k)];
                e.due = t0 + RD_LAT + k;
                sbq.push_back(e);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic sync_refresh(output int a);
        a = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ifc.local_refresh_ack) begin a = cyc; break; end
        end
        checks++;
        if (a < 0) begin errors++; $display("FAIL refresh_ack_timeout: no ack in 200 cycles, required one"); end
        @(posedge clk); #1;
    endtask

    task automatic do_init();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ifc.local_ready, ifc.local_rdata_valid, ifc.local_init_done, ifc.local_refresh_ack} !== 4'b0 ||
            ifc.local_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b done=%b ack=%b rdata=%h, required all 0",
                     ifc.local_ready, ifc.local_rdata_valid, ifc.local_init_done, ifc.local_refresh_ack, ifc.local_rdata);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= INIT_CYC; i++) begin
            @(posedge clk); #1;
            checks++;
            if (i < INIT_CYC) begin
                if ({ifc.local_ready, ifc.local_rdata_valid, ifc.local_init_done, ifc.local_refresh_ack} !== 4'b0) begin
                    errors++;
                    $display("FAIL init_early: edge %0d rdy=%b vld=%b done=%b ack=%b, required 0",
                             i, ifc.local_ready, ifc.local_rdata_valid, ifc.local_init_done, ifc.local_refresh_ack);
                end
            end else if (ifc.local_init_done !== 1'b1 || ifc.local_ready !== 1'b1) begin
                errors++;
                $display("FAIL init_done: edge %0d done=%b rdy=%b, required 1/1", i, ifc.local_init_done, ifc.local_ready);
            end
        end
    endtask

    task automatic test_reset();
        do_init();
    endtask

    task automatic test_write_read();
        int a, t0;
        for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0 + k; wbe[k] = 4'hF; end
        sync_refresh(a);
        wr_burst(24'h000010, 7'd4, -1, 0);
        rd_burst(24'h000010, 7'd4, t0);
        for (int c = t0 + 1; c <= t0 + RD_LAT + 4; c++) begin
            @(negedge clk);
            checks++;
            if (ifc.local_ready !== (c == t0 + RD_LAT + 4)) begin
                errors++;
                $display("FAIL rd_ready_window: cycle t0+%0d ready=%b, required %b", c - t0, ifc.local_ready, c == t0 + RD_LAT + 4);
            end
        end
        drain();
    endtask

    task automatic test_gapped_be();
        int t0;
        wd[0] = 32'hAAAA0000; wd[1] = 32'h12345678; wd[2] = 32'hBBBB0000;
        for (int k = 0; k < 3; k++) wbe[k] = 4'hF;
        wr_burst(24'h000020, 7'd3, -1, 0);
        wd[0] = 32'h11111111; wd[1] = 32'hFFFFFFFF; wd[2] = 32'h33333333;
        wbe[1] = 4'b0011;
        wr_burst(24'h000020, 7'd3, 1, 2);
        rd_burst(24'h000020, 7'd3, t0);
        drain();
    endtask

    task automatic test_wrap();
        int t0;
        for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); wbe[k] = 4'hF; end
        wr_burst(24'h0003FE, 7'd4, -1, 0);
        rd_burst(24'h0003FE, 7'd4, t0);
        drain();
        rd_burst(24'h0403FE, 7'd2, t0);
        drain();
        rd_burst(24'h000000, 7'd2, t0);
        drain();
    endtask

    task automatic test_back_to_back();
        int t0;
        wd[0] = 32'hC0FFEE01; wbe[0] = 4'hF;
        wr_burst(24'h000050, 7'd1, -1, 0);
        rd_burst(24'h000050, 7'd1, t0);
        drain();
        wd[0] = 32'h5A5A0002; wbe[0] = 4'hF;
        wr_burst(24'h000051, 7'd0, -1, 0);
        rd_burst(24'h000051, 7'd0, t0);
        rd_burst(24'h000050, 7'd2, t0);
        drain();
    endtask

    task automatic test_refresh();
        int a, t0, last, ack_at;
        logic exp_rdy, exp_ack;
        for (int k = 0; k < 8; k++) begin wd[k] = 32'hD000_0000 + 32'(k * 17); wbe[k] = 4'hF; end
        wr_burst(24'h000200, 7'd8, -1, 0);
        sync_refresh(a);
        sync_refresh(a);
        while (cyc < a + 24) begin @(posedge clk); #1; end
        rd_burst(24'h000200, 7'd8, t0);
        last   = t0 + RD_LAT + 8;
        ack_at = last + 1;
        for (int c = t0 + 1; c <= last + 1 + REF_CYC; c++) begin
            @(negedge clk);
            exp_rdy = (c == last + 1 + REF_CYC);
            exp_ack = (c == ack_at);
            checks++;
            if (ifc.local_ready !== exp_rdy || ifc.local_refresh_ack !== exp_ack) begin
                errors++;
                $display("FAIL refresh_window: cycle t0+%0d rdy=%b ack=%b, required rdy=%b ack=%b",
                         c - t0, ifc.local_ready, ifc.local_refresh_ack, exp_rdy, exp_ack);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_read();
        int t0;
        for (int k = 0; k < 8; k++) begin wd[k] = 32'hE100_0000 + 32'(k); wbe[k] = 4'hF; end
        wr_burst(24'h000100, 7'd8, -1, 0);
        rd_burst(24'h000100, 7'd8, t0);
        while (cyc < t0 + RD_LAT + 2) begin @(posedge clk); #1; end
        checks++;
        if (ifc.local_rdata_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_beat2: valid=%b, required 1", ifc.local_rdata_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifc.local_ready, ifc.local_rdata_valid, ifc.local_init_done, ifc.local_refresh_ack} !== 4'b0 ||
            ifc.local_rdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_read_reset: rdy=%b vld=%b done=%b rdata=%h, required all 0",
                     ifc.local_ready, ifc.local_rdata_valid, ifc.local_init_done, ifc.local_rdata);
        end
        sbq.delete();
        do_init();
        rd_burst(24'h000100, 7'd8, t0);
        drain();
    endtask

    initial begin
        rst_n  = 1'b0;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mdl[i] = '0;
        idle_inputs();
        fork monitor(); join_none
        test_reset();
        test_write_read();
        test_gapped_be();
        test_wrap();
        test_back_to_back();
        test_refresh();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
